// File: rtl/peak_interval_timer_if.sv
// Interval delivery bus between the peak interval timer and the BPM calculator.
// Ports: interval (CNT_W), interval_valid, interval_ready; master = timer side.
interface peak_interval_timer_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] interval;
    logic             interval_valid;
    logic             interval_ready;

    modport master (
        output interval,
        output interval_valid,
        input  interval_ready
    );

    modport slave (
        input  interval,
        input  interval_valid,
        output interval_ready
    );
endinterface

// File: rtl/peak_interval_timer.sv
// Peak-to-peak interval timer: counts ticks between accepted peaks, rejects
// peaks in the refractory window, abandons intervals at timeout and hands
// each interval to the BPM calculator over a valid/ready handshake.
// Ports: clk, rst (async, active high), en, tick, peak_detected, continuous,
//        bus (interval/interval_valid/interval_ready), rejected, timeout,
//        overrun (one-cycle registered pulses).
module peak_interval_timer #(
    parameter int CNT_W        = 8,
    parameter int MIN_INTERVAL = 8,
    parameter int MAX_INTERVAL = 75
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         tick,
    input  logic                         peak_detected,
    input  logic                         continuous,
    peak_interval_timer_if.master        bus,
    output logic                         rejected,
    output logic                         timeout,
    output logic                         overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INTERVAL);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic             valid_q, valid_d;
    logic             rejected_q, rejected_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    logic xfer;

    assign xfer = valid_q & bus.interval_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        interval_d = interval_q;
        valid_d    = valid_q;
        rejected_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            // A capture below re-raises valid in the same cycle.
            if (xfer) begin
                valid_d = 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (peak_detected) begin
                        state_d = S_COUNT;
                        cnt_d   = '0;
                    end
                end

                S_COUNT: begin
                    if (peak_detected && cnt_q >= MIN_C) begin
                        // Peak wins over a same-cycle tick.
                        interval_d = cnt_q;
                        valid_d    = 1'b1;
                        overrun_d  = valid_q & ~bus.interval_ready;
                        if (continuous) begin
                            cnt_d = '0;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        if (peak_detected) begin
                            rejected_d = 1'b1;
                        end
                        if (tick) begin
                            if (cnt_q == MAX_C) begin
                                timeout_d = 1'b1;
                                state_d   = S_IDLE;
                                cnt_d     = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (xfer) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            interval_q <= '0;
            valid_q    <= 1'b0;
            rejected_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
            valid_q    <= valid_d;
            rejected_q <= rejected_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.interval       = interval_q;
    assign bus.interval_valid = valid_q;
    assign rejected           = rejected_q;
    assign timeout            = timeout_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_peak_interval_timer.sv
// Directed bench for peak_interval_timer with a transfer scoreboard.
// Expected intervals are queued by stimulus; a monitor checks each transfer.
module tb_peak_interval_timer;

    logic clk;
    logic rst;
    logic en;
    logic tick;
    logic peak_detected;
    logic continuous;
    logic rejected;
    logic timeout;
    logic overrun;

    int n_chk;
    int n_fail;
    int exp_q[$];

    peak_interval_timer_if #(.CNT_W(8)) bus ();

    peak_interval_timer #(
        .CNT_W(8),
        .MIN_INTERVAL(8),
        .MAX_INTERVAL(75)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .tick(tick),
        .peak_detected(peak_detected),
        .continuous(continuous),
        .bus(bus),
        .rejected(rejected),
        .timeout(timeout),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic t);
        peak_detected = p;
        tick = t;
        @(posedge clk);
        #1;
        peak_detected = 1'b0;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    // Transfer happens on the next rising edge when valid & ready here.
    always @(negedge clk) begin
        if (!rst && bus.interval_valid && bus.interval_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_unexpected: got %0d, expected none",
                         bus.interval);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(bus.interval) != e) begin
                    n_fail++;
                    $display("FAIL xfer_value: got %0d, expected %0d",
                             bus.interval, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        en = 1'b0;
        tick = 1'b0;
        peak_detected = 1'b0;
        continuous = 1'b0;
        bus.interval_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", bus.interval_valid, 0);
        chk("rst_interval", bus.interval, 0);
        chk("rst_pulses", {rejected, timeout, overrun}, 0);
        rst = 1'b0;
        en = 1'b1;
        step(0, 0);

        // Single-shot, ready held high
        bus.interval_ready = 1'b1;
        step(1, 0);
        ticks(20);
        exp_q.push_back(20);
        step(1, 0);
        chk("ss_valid", bus.interval_valid, 1);
        chk("ss_interval", bus.interval, 20);
        step(0, 0);
        chk("ss_valid_drop", bus.interval_valid, 0);
        step(1, 0);
        ticks(9);
        exp_q.push_back(9);
        step(1, 0);
        chk("ss_restart", bus.interval, 9);
        step(0, 0);

        // Refractory
        step(1, 0);
        ticks(5);
        step(1, 0);
        chk("refr_rej", rejected, 1);
        chk("refr_nocap", bus.interval_valid, 0);
        step(0, 0);
        chk("refr_rej_1cyc", rejected, 0);
        ticks(15);
        exp_q.push_back(20);
        step(1, 0);
        chk("refr_interval", bus.interval, 20);
        step(0, 0);

        // Timeout
        step(1, 0);
        ticks(75);
        chk("tmo_early", timeout, 0);
        ticks(1);
        chk("tmo_pulse", timeout, 1);
        chk("tmo_valid", bus.interval_valid, 0);
        ticks(1);
        chk("tmo_1cyc", timeout, 0);
        ticks(10);
        step(1, 0);
        chk("tmo_idle_nocap", bus.interval_valid, 0);
        chk("tmo_idle_norej", rejected, 0);
        en = 1'b0;
        step(0, 0);
        en = 1'b1;

        // Continuous with ready low: overrun
        continuous = 1'b1;
        bus.interval_ready = 1'b0;
        step(1, 0);
        ticks(20);
        step(1, 0);
        chk("cont_int1", bus.interval, 20);
        chk("cont_valid1", bus.interval_valid, 1);
        chk("cont_noovr", overrun, 0);
        ticks(30);
        chk("cont_valid_held", bus.interval_valid, 1);
        exp_q.push_back(30);
        step(1, 0);
        chk("cont_int2", bus.interval, 30);
        chk("cont_ovr", overrun, 1);
        step(0, 0);
        chk("cont_ovr_1cyc", overrun, 0);
        bus.interval_ready = 1'b1;
        step(0, 0);
        chk("cont_valid_drop", bus.interval_valid, 0);
        en = 1'b0;
        step(0, 0);
        en = 1'b1;

        // Same-cycle peak and tick, continuous
        bus.interval_ready = 1'b0;
        step(1, 0);
        ticks(12);
        step(1, 1);
        chk("same_int", bus.interval, 12);
        ticks(8);
        exp_q.push_back(8);
        step(1, 0);
        chk("same_restart0", bus.interval, 8);
        chk("same_ovr", overrun, 1);
        bus.interval_ready = 1'b1;
        step(0, 0);
        en = 1'b0;
        step(0, 0);
        en = 1'b1;

        // Same-cycle peak and tick, single-shot
        continuous = 1'b0;
        step(1, 0);
        ticks(12);
        exp_q.push_back(12);
        step(1, 1);
        chk("same_ss_int", bus.interval, 12);
        step(0, 0);

        // Abort mid-COUNT
        step(1, 0);
        ticks(10);
        en = 1'b0;
        step(0, 0);
        chk("abort_cnt_valid", bus.interval_valid, 0);
        chk("abort_cnt_pulses", {rejected, timeout, overrun}, 0);
        en = 1'b1;
        step(1, 0);
        chk("abort_cnt_idle", rejected, 0);
        ticks(8);
        exp_q.push_back(8);
        step(1, 0);
        chk("abort_cnt_int", bus.interval, 8);
        step(0, 0);

        // Abort in HOLD with pending interval
        bus.interval_ready = 1'b0;
        step(1, 0);
        ticks(9);
        step(1, 0);
        chk("hold_valid", bus.interval_valid, 1);
        en = 1'b0;
        step(0, 0);
        chk("abort_hold_valid", bus.interval_valid, 0);
        chk("abort_hold_keep", bus.interval, 9);
        en = 1'b1;
        bus.interval_ready = 1'b1;
        step(0, 0);
        step(1, 0);
        ticks(8);
        exp_q.push_back(8);
        step(1, 0);
        chk("abort_hold_idle", bus.interval_valid, 1);
        step(0, 0);

        // Async reset mid-cycle
        bus.interval_ready = 1'b0;
        step(1, 0);
        ticks(10);
        step(1, 0);
        chk("arst_pre", bus.interval, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.interval_valid, 0);
        chk("arst_interval", bus.interval, 0);
        step(0, 0);
        rst = 1'b0;
        step(0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
